filter_sequencer: RTL and testbench
===================================

Name: filter_sequencer

Overview:
- Sequences the paired I/Q low-pass filter instances of the IQ demodulator.
- Buffers incoming I/Q sample pairs and issues them to both filters simultaneously, using a programmable burst/gap duty pattern (default 4 on, 1 off).
- Re-aligns the independently valid I and Q filter outputs into a single paired output stream for the downstream demodulator.
- Flags a sticky error if the two filter outputs skew beyond the alignment buffer.

Parameters:
- W, 5: sample width, signed two's complement.
- IN_DEPTH, 4: input pair FIFO depth, power of 2, ≥2.
- ALIGN_DEPTH, 4: per-channel output alignment FIFO depth, power of 2, ≥2.
- BURST, 4: consecutive samples issued per burst, ≥1.
- GAP, 1: idle cycles forced after each burst, ≥0.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input pair valid.
- s_ready  out  1  input FIFO not full.
- s_i  in  W  input I sample.
- s_q  in  W  input Q sample.
- f_in_valid  out  1  in_valid driven to both filters.
- fi_data  out  W  I filter data_in.
- fq_data  out  W  Q filter data_in.
- fi_pret  in  1  I filter pret (ready).
- fq_pret  in  1  Q filter pret (ready).
- fi_out_valid  in  1  I filter out_valid.
- fi_out  in  W  I filter data_out.
- fq_out_valid  in  1  Q filter out_valid.
- fq_out  in  W  Q filter data_out.
- m_valid  out  1  aligned output pair valid; downstream always accepts.
- m_i  out  W  aligned I result.
- m_q  out  W  aligned Q result.
- err  out  1  sticky alignment overflow flag.

Behaviour:
- Reset (async, active-high):
  - All outputs 0; s_ready goes 1 on the first clock after reset deasserts.
  - FIFOs empty, FSM in IDLE, counters 0.
  - Reset mid-burst discards all buffered pairs and pending alignment data.
- Input:
  - Push when s_valid & s_ready.
  - s_ready = !in_full, computed from registered count.
  - No push when full, even if a pop occurs in the same cycle.
- Issue condition: can_issue = in_fifo nonempty & fi_pret & fq_pret & state ∈ {IDLE, BURST}.
- On issue (cycle t):
  - Pop one pair.
  - At t+1, registered: f_in_valid=1, fi_data=I, fq_data=Q.
  - Otherwise f_in_valid=0 and data holds its last value.
  - Minimum latency from s handshake to f_in_valid: 2 cycles.
- FSM, burst counter bcnt:
  - IDLE: on issue, bcnt=1; if BURST==1 go to GAP (or stay in IDLE if GAP==0), else go to BURST.
  - BURST: on issue, bcnt++. When bcnt reaches BURST, go to GAP (IDLE if GAP==0) and set bcnt=0. Stall (FIFO empty or either pret low) holds bcnt and state.
  - GAP: no issue for exactly GAP cycles (gcnt counts 0..GAP-1), then go to IDLE.
- Alignment:
  - fi_out_valid pushes fi_out into align_i; fq_out_valid pushes fq_out into align_q; independently, same cycle allowed.
  - When both align FIFOs are nonempty, pop both. Next cycle: m_valid=1 with the popped pair.
  - A push into a full align FIFO drops the sample and sets err=1. err clears only on reset.
  - Pop and push in the same cycle on a full align FIFO is legal: no drop, no err.
- Both filters share f_in_valid, so their pret/out_valid are expected to match. Skew up to ALIGN_DEPTH samples is tolerated.

Optional Feature:
- Macro FILTER_SEQ_STATS_EN.
- When defined: adds output ports issued_cnt[15:0] (pairs issued) and paired_cnt[15:0] (m_valid pulses). Both are 16-bit wrapping counters, 0 on reset, updated one cycle after the event.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package filter_seq_pkg:
  - sample_t (logic signed [W-1:0]) and pair_t struct {sample_t i, q}.
  - State enum seq_state_t {IDLE, BURST, GAP}.
  - Default constants: W, BURST, GAP.
- One sub-module, sync_fifo: parameterised width/depth, registered count, full/empty outputs.
- Instances: one for input pairs (width 2W, IN_DEPTH); two for align_i/align_q (width W, ALIGN_DEPTH).

Test Plan:
- Basic pacing: push 12 pairs back-to-back with pret=1 → f_in_valid pattern 1111 0 1111 0 1111. fi_data/fq_data equal the pushed values in order; first f_in_valid exactly 2 cycles after first handshake.
- Backpressure: hold s_valid=1 with pret=0 → s_ready drops after exactly 4 pushes, no f_in_valid. Raise pret → issue resumes and bcnt continues correctly.
- Stall mid-burst: drop fq_pret for 3 cycles after 2 issues → f_in_valid=0 for those cycles, then 2 more issues, then the 1-cycle gap.
- Skewed outputs: fi_out_valid pulses 3 times (values 1,2,3) before any fq_out_valid, then fq pulses values -1,-2,-3 → m_valid pairs (1,-1),(2,-2),(3,-3); err stays 0.
- Overflow: 5 fi_out_valid pulses with no fq_out_valid (ALIGN_DEPTH=4) → err=1 on the cycle after the 5th pulse; 5th sample dropped. Assert reset mid-stream → err=0, m_valid=0, s_ready=1 after release.
- With FILTER_SEQ_STATS_EN: after 12 issues and 10 pairs → issued_cnt=12, paired_cnt=10. Wrap check: 65536 issues returns issued_cnt to 0.

Source files
------------

// File: rtl/filter_seq_pkg.sv
// filter_seq_pkg
// Shared types and default constants for the I/Q filter sequencer.
//   DEFAULT_W     : sample width (signed two's complement)
//   DEFAULT_BURST : consecutive samples issued per burst
//   DEFAULT_GAP   : idle cycles forced after each burst
//   sample_t      : one signed sample
//   pair_t        : one I/Q sample pair
//   seq_state_t   : issue pacing states
package filter_seq_pkg;

    localparam int DEFAULT_W     = 5;
    localparam int DEFAULT_BURST = 4;
    localparam int DEFAULT_GAP   = 1;

    typedef logic signed [DEFAULT_W-1:0] sample_t;

    typedef struct packed {
        sample_t i;
        sample_t q;
    } pair_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/filter_sequencer_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a registered occupancy count.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push_i, wdata_i : write request and data
//   pop_i           : read request; rdata_o shows the head entry (show-ahead)
//   full_o, empty_o : status derived from the registered count
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; callers that must never push while full gate push_i themselves.
// Pushes that are not accepted are silently discarded.
module sync_fifo
    import filter_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is tracked
    // by the pointers and count, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/filter_sequencer.sv
// filter_sequencer
// Feeds paired I/Q low-pass filters from an input pair FIFO using a
// burst/gap duty pattern, then re-aligns the two filter output streams into
// one paired stream. A push into a full alignment FIFO drops the sample and
// sets the sticky err flag.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   s_valid/s_ready/s_i/s_q    : input pair stream
//   f_in_valid/fi_data/fq_data : registered issue to both filters
//   fi_pret/fq_pret            : filter ready inputs
//   fi_out_valid/fi_out        : I filter result
//   fq_out_valid/fq_out        : Q filter result
//   m_valid/m_i/m_q            : aligned output pair (always accepted)
//   err                        : sticky alignment overflow
// Optional macro FILTER_SEQ_STATS_EN adds issued_cnt/paired_cnt
// (16-bit wrapping counters of issued pairs and m_valid pulses).
module filter_sequencer
    import filter_seq_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int IN_DEPTH    = 4,
    parameter int ALIGN_DEPTH = 4,
    parameter int BURST       = DEFAULT_BURST,
    parameter int GAP         = DEFAULT_GAP
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_i,
    input  logic [W-1:0] s_q,
    output logic         f_in_valid,
    output logic [W-1:0] fi_data,
    output logic [W-1:0] fq_data,
    input  logic         fi_pret,
    input  logic         fq_pret,
    input  logic         fi_out_valid,
    input  logic [W-1:0] fi_out,
    input  logic         fq_out_valid,
    input  logic [W-1:0] fq_out,
    output logic         m_valid,
    output logic [W-1:0] m_i,
    output logic [W-1:0] m_q,
    output logic         err
`ifdef FILTER_SEQ_STATS_EN
    ,
    output logic [15:0]  issued_cnt,
    output logic [15:0]  paired_cnt
`endif
);

    localparam int BW = $clog2(BURST + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    // ---------------- input pair FIFO ----------------
    logic           in_full;
    logic           in_empty;
    logic [2*W-1:0] in_rdata;
    logic           in_push;
    logic           can_issue;
    logic           rdy_q;

    // rdy_q keeps s_ready low during reset and until the first clock after it.
    assign s_ready = rdy_q & ~in_full;
    assign in_push = s_valid & s_ready;

    sync_fifo #(.WIDTH(2*W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_push),
        .pop_i   (can_issue),
        .wdata_i ({s_i, s_q}),
        .rdata_o (in_rdata),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    // ---------------- issue pacing FSM ----------------
    seq_state_t     state_q;
    logic [BW-1:0]  bcnt_q;
    logic [GW-1:0]  gcnt_q;
    logic           f_in_valid_q;
    logic [W-1:0]   fi_data_q;
    logic [W-1:0]   fq_data_q;

    assign can_issue = ~in_empty & fi_pret & fq_pret &
                       ((state_q == ST_IDLE) | (state_q == ST_BURST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q        <= 1'b0;
            state_q      <= ST_IDLE;
            bcnt_q       <= '0;
            gcnt_q       <= '0;
            f_in_valid_q <= 1'b0;
            fi_data_q    <= '0;
            fq_data_q    <= '0;
        end else begin
            rdy_q        <= 1'b1;
            f_in_valid_q <= can_issue;
            if (can_issue) begin
                fi_data_q <= in_rdata[2*W-1:W];
                fq_data_q <= in_rdata[W-1:0];
            end
            unique case (state_q)
                ST_IDLE, ST_BURST: begin
                    if (can_issue) begin
                        // bcnt counts issues already made in this burst, so
                        // BURST-1 means this issue completes it.
                        if (bcnt_q == BW'(BURST - 1)) begin
                            bcnt_q  <= '0;
                            state_q <= (GAP == 0) ? ST_IDLE : ST_GAP;
                        end else begin
                            bcnt_q  <= bcnt_q + BW'(1);
                            state_q <= ST_BURST;
                        end
                    end
                end
                ST_GAP: begin
                    if (gcnt_q == GW'(GAP - 1)) begin
                        gcnt_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        gcnt_q  <= gcnt_q + GW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign f_in_valid = f_in_valid_q;
    assign fi_data    = fi_data_q;
    assign fq_data    = fq_data_q;

    // ---------------- output alignment ----------------
    logic         ai_full, ai_empty, aq_full, aq_empty;
    logic [W-1:0] ai_rdata, aq_rdata;
    logic         pop_both;
    logic         drop_i, drop_q;
    logic         m_valid_q;
    logic [W-1:0] m_i_q, m_q_q;
    logic         err_q;

    assign pop_both = ~ai_empty & ~aq_empty;
    // A same-cycle pop frees a slot, so only a push into a full FIFO that is
    // not also being popped loses data.
    assign drop_i   = fi_out_valid & ai_full & ~pop_both;
    assign drop_q   = fq_out_valid & aq_full & ~pop_both;

    sync_fifo #(.WIDTH(W), .DEPTH(ALIGN_DEPTH)) u_align_i (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fi_out_valid),
        .pop_i   (pop_both),
        .wdata_i (fi_out),
        .rdata_o (ai_rdata),
        .full_o  (ai_full),
        .empty_o (ai_empty)
    );

    sync_fifo #(.WIDTH(W), .DEPTH(ALIGN_DEPTH)) u_align_q (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fq_out_valid),
        .pop_i   (pop_both),
        .wdata_i (fq_out),
        .rdata_o (aq_rdata),
        .full_o  (aq_full),
        .empty_o (aq_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_i_q     <= '0;
            m_q_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            m_valid_q <= pop_both;
            if (pop_both) begin
                m_i_q <= ai_rdata;
                m_q_q <= aq_rdata;
            end
            if (drop_i | drop_q) err_q <= 1'b1;
        end
    end

    assign m_valid = m_valid_q;
    assign m_i     = m_i_q;
    assign m_q     = m_q_q;
    assign err     = err_q;

`ifdef FILTER_SEQ_STATS_EN
    logic [15:0] issued_cnt_q;
    logic [15:0] paired_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_cnt_q <= '0;
            paired_cnt_q <= '0;
        end else begin
            if (can_issue) issued_cnt_q <= issued_cnt_q + 16'd1;
            if (m_valid_q) paired_cnt_q <= paired_cnt_q + 16'd1;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign paired_cnt = paired_cnt_q;
`endif

endmodule

// File: tb/tb_filter_sequencer.sv
// tb_filter_sequencer
// Directed bench for filter_sequencer. A queue-based model predicts every
// registered output; a negedge process compares the DUT against it each
// cycle, and the stimulus thread adds hand-computed pattern/value checks.
// Optional macro FILTER_SEQ_STATS_EN also connects and checks the counters.
module tb_filter_sequencer;
    import filter_seq_pkg::*;

    localparam int W           = DEFAULT_W;
    localparam int IN_DEPTH    = 4;
    localparam int ALIGN_DEPTH = 4;
    localparam int BURST       = DEFAULT_BURST;
    localparam int GAP         = DEFAULT_GAP;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_i = '0;
    logic [W-1:0] s_q = '0;
    logic         f_in_valid;
    logic [W-1:0] fi_data, fq_data;
    logic         fi_pret = 1'b0;
    logic         fq_pret = 1'b0;
    logic         fi_out_valid = 1'b0;
    logic [W-1:0] fi_out = '0;
    logic         fq_out_valid = 1'b0;
    logic [W-1:0] fq_out = '0;
    logic         m_valid;
    logic [W-1:0] m_i, m_q;
    logic         err;
`ifdef FILTER_SEQ_STATS_EN
    logic [15:0]  issued_cnt, paired_cnt;
`endif

    always #5 clk = ~clk;

    filter_sequencer #(
        .W(W), .IN_DEPTH(IN_DEPTH), .ALIGN_DEPTH(ALIGN_DEPTH),
        .BURST(BURST), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
        .f_in_valid(f_in_valid), .fi_data(fi_data), .fq_data(fq_data),
        .fi_pret(fi_pret), .fq_pret(fq_pret),
        .fi_out_valid(fi_out_valid), .fi_out(fi_out),
        .fq_out_valid(fq_out_valid), .fq_out(fq_out),
        .m_valid(m_valid), .m_i(m_i), .m_q(m_q), .err(err)
`ifdef FILTER_SEQ_STATS_EN
        , .issued_cnt(issued_cnt), .paired_cnt(paired_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    pair_t   in_q[$];
    sample_t ai_q[$];
    sample_t aq_q[$];
    bit      rdy_m;
    int      gap_left, burst_n;
    bit      exp_fv, exp_mv, exp_err;
    sample_t exp_fi, exp_fq, exp_mi, exp_mq;
    int      exp_issued, exp_paired;

    always @(posedge clk or posedge reset) begin : model
        int    pre;
        bit    do_issue, do_push, do_pop2;
        pair_t p;
        if (reset) begin
            in_q.delete(); ai_q.delete(); aq_q.delete();
            rdy_m = 0; gap_left = 0; burst_n = 0;
            exp_fv = 0; exp_mv = 0; exp_err = 0;
            exp_fi = '0; exp_fq = '0; exp_mi = '0; exp_mq = '0;
            exp_issued = 0; exp_paired = 0;
        end else begin
            // Issue side: a pair leaves when one is buffered, both filters are
            // ready and no forced idle cycle is pending.
            pre      = in_q.size();
            do_push  = s_valid && rdy_m && (pre < IN_DEPTH);
            do_issue = 0;
            if (gap_left > 0) gap_left--;
            else if (pre > 0 && fi_pret && fq_pret) do_issue = 1;
            exp_fv = do_issue;
            if (do_issue) begin
                p = in_q.pop_front();
                exp_fi = p.i;
                exp_fq = p.q;
                exp_issued++;
                burst_n++;
                if (burst_n == BURST) begin
                    burst_n  = 0;
                    gap_left = GAP;
                end
            end
            if (do_push) begin
                p.i = s_i;
                p.q = s_q;
                in_q.push_back(p);
            end
            rdy_m = 1;
            // Alignment side.
            if (exp_mv) exp_paired++;
            do_pop2 = (ai_q.size() > 0) && (aq_q.size() > 0);
            exp_mv  = do_pop2;
            if (do_pop2) begin
                exp_mi = ai_q.pop_front();
                exp_mq = aq_q.pop_front();
            end
            if (fi_out_valid) begin
                if (ai_q.size() < ALIGN_DEPTH) ai_q.push_back(fi_out);
                else exp_err = 1;
            end
            if (fq_out_valid) begin
                if (aq_q.size() < ALIGN_DEPTH) aq_q.push_back(fq_out);
                else exp_err = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit fv_log[$];
    bit log_en = 0;

    always @(negedge clk) begin
        if (log_en) fv_log.push_back(f_in_valid);
        check("s_ready", s_ready, (rdy_m && in_q.size() < IN_DEPTH) ? 1 : 0);
        check("f_in_valid", f_in_valid, exp_fv);
        if (exp_fv) begin
            check("fi_data", $signed(fi_data), exp_fi);
            check("fq_data", $signed(fq_data), exp_fq);
        end
        check("m_valid", m_valid, exp_mv);
        if (exp_mv) begin
            check("m_i", $signed(m_i), exp_mi);
            check("m_q", $signed(m_q), exp_mq);
        end
        check("err", err, exp_err);
`ifdef FILTER_SEQ_STATS_EN
        check("issued_cnt", issued_cnt, exp_issued % 65536);
        check("paired_cnt", paired_cnt, exp_paired % 65536);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input int iv, input int qv);
        bit hs;
        hs = 0;
        s_valid = 1'b1;
        s_i = W'(iv);
        s_q = W'(qv);
        for (int t = 0; t < 50 && !hs; t++) begin
            hs = s_ready;
            next();
        end
        if (!hs) check("push_timeout", 0, 1);
    endtask

    task automatic check_log(input string name, input string pat);
        check({name, "_len"}, fv_log.size(), pat.len());
        for (int i = 0; i < pat.len() && i < fv_log.size(); i++)
            check(name, int'(fv_log[i]), (pat.getc(i) == "1") ? 1 : 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        int n_hs;
        bit hs;

        // Reset state.
        repeat (2) next();
        check("rst_s_ready", s_ready, 0);
        check("rst_f_in_valid", f_in_valid, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        check("rel_s_ready_same_cycle", s_ready, 0);
        next();
        check("rel_s_ready_first_clk", s_ready, 1);

        // Basic pacing: 12 back-to-back pairs, 4 on / 1 off, 2-cycle latency.
        fi_pret = 1'b1;
        fq_pret = 1'b1;
        fv_log.delete();
        log_en = 1;
        for (int k = 1; k <= 12; k++) push_pair(k, -k);
        s_valid = 1'b0;
        repeat (6) next();
        log_en = 0;
        check_log("pacing", "001111011110111100");

        // Backpressure: pret low, s_valid held; only IN_DEPTH pushes fit.
        fi_pret = 1'b0;
        fq_pret = 1'b0;
        fv_log.delete();
        log_en = 1;
        n_hs = 0;
        s_valid = 1'b1;
        s_i = W'(-8);
        s_q = W'(7);
        for (int t = 0; t < 6; t++) begin
            hs = s_ready;
            next();
            if (hs) begin
                n_hs++;
                s_i = W'(-8 + n_hs);
                s_q = W'(7 - n_hs);
            end
        end
        check("bp_push_count", n_hs, 4);
        check("bp_s_ready_low", s_ready, 0);
        s_valid = 1'b0;
        fi_pret = 1'b1;
        fq_pret = 1'b1;
        repeat (6) next();
        log_en = 0;
        check_log("backpressure", "000000011110");

        // Stall mid-burst: fq_pret low for 3 cycles after 2 issues.
        fi_pret = 1'b0;
        fq_pret = 1'b0;
        for (int k = 0; k < 4; k++) push_pair(10 + k, -10 - k);
        s_valid = 1'b0;
        fv_log.delete();
        log_en = 1;
        fi_pret = 1'b1;
        fq_pret = 1'b1;
        next();
        next();
        check("stall_room_for_push", s_ready, 1);
        fq_pret = 1'b0;
        s_valid = 1'b1; s_i = W'(3); s_q = W'(-3);
        next();
        s_i = W'(4); s_q = W'(-4);
        next();
        s_valid = 1'b0;
        next();
        fq_pret = 1'b1;
        repeat (7) next();
        log_en = 0;
        check_log("stall", "011000110110");

        // Skewed filter outputs: I three ahead of Q.
        fi_out_valid = 1'b1;
        fi_out = W'(1); next();
        fi_out = W'(2); next();
        fi_out = W'(3); next();
        fi_out_valid = 1'b0;
        fq_out_valid = 1'b1;
        fq_out = W'(-1); next();
        fq_out = W'(-2); next();
        check("skew_m_valid0", m_valid, 1);
        check("skew_m_i0", $signed(m_i), 1);
        check("skew_m_q0", $signed(m_q), -1);
        fq_out = W'(-3); next();
        fq_out_valid = 1'b0;
        check("skew_m_i1", $signed(m_i), 2);
        check("skew_m_q1", $signed(m_q), -2);
        next();
        check("skew_m_i2", $signed(m_i), 3);
        check("skew_m_q2", $signed(m_q), -3);
        next();
        check("skew_m_valid_end", m_valid, 0);
        check("skew_err", err, 0);

        // Overflow: 5 I results, no Q; the 5th is dropped and err latches.
        fi_out_valid = 1'b1;
        fi_out = W'(4); next();
        fi_out = W'(5); next();
        fi_out = W'(6); next();
        fi_out = W'(7); next();
        check("ovf_err_before", err, 0);
        fi_out = W'(8); next();
        fi_out_valid = 1'b0;
        check("ovf_err_after", err, 1);
        fq_out_valid = 1'b1;
        fq_out = W'(-4); next();
        fq_out = W'(-5); next();
        check("ovf_m_i0", $signed(m_i), 4);
        check("ovf_m_q0", $signed(m_q), -4);
        fq_out = W'(-6); next();
        fq_out = W'(-7); next();
        fq_out_valid = 1'b0;
        next();
        check("ovf_m_i3", $signed(m_i), 7);
        check("ovf_m_q3", $signed(m_q), -7);
        next();
        check("ovf_no_dropped_pair", m_valid, 0);
        check("ovf_err_sticky", err, 1);

        // Reset mid-stream discards buffered pairs and pending alignment data.
        fi_pret = 1'b0;
        fq_pret = 1'b0;
        for (int k = 0; k < 3; k++) push_pair(k, k);
        s_valid = 1'b0;
        fi_out_valid = 1'b1;
        fi_out = W'(9); next();
        fi_out_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_err", err, 0);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_s_ready", s_ready, 0);
        next();
        next();
        reset = 1'b0;
        next();
        check("mid_rel_s_ready", s_ready, 1);
        fi_pret = 1'b1;
        fq_pret = 1'b1;
        fq_out_valid = 1'b1;
        fq_out = W'(-9); next();
        fq_out_valid = 1'b0;
        repeat (3) next();
        check("mid_rel_no_issue", f_in_valid, 0);
        check("mid_rel_no_pair", m_valid, 0);

        // Recovery: normal traffic after reset.
        for (int k = 0; k < 5; k++) push_pair(k - 2, 2 - k);
        s_valid = 1'b0;
        fi_out_valid = 1'b1;
        fq_out_valid = 1'b1;
        fi_out = W'(11); fq_out = W'(-12); next();
        fi_out = W'(13); fq_out = W'(-14); next();
        fi_out_valid = 1'b0;
        fq_out_valid = 1'b0;
        repeat (10) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
